// File: rtl/hud_counter_bank.sv
// hud_counter_bank: bank of NCH saturating game-stat registers written over an
// Avalon slave port, with a once-per-frame sequential double-dabble sweep that
// converts a snapshot of every channel into NDIG BCD digits for the HUD renderer.
// Optional build macro HUD_LEADING_ZERO_BLANK_EN replaces leading zero digits
// (above the units digit) with the blank glyph code 4'hF when a result is stored.
module hud_counter_bank #(
    parameter int NCH    = 4,
    parameter int VAL_W  = 8,
    parameter int NDIG   = 3,
    parameter int ADDR_W = 4,
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    input  logic              frame_start,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [NDIG*4-1:0] digit_bcd,
    output logic              busy,
    output logic              frame_done
);

    localparam int DW    = NDIG * 4;
    localparam int CNT_W = $clog2(VAL_W);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);
    localparam logic [31:0]      MAX_DEC = 32'(10 ** NDIG - 1);
    localparam logic [VAL_W-1:0] VAL_MAX = {VAL_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_STORE = 3'd3,
        ST_NEXT  = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [VAL_W-1:0]   value_r [NCH];
    logic [VAL_W-1:0]   snap_r  [NCH];
    logic [DW-1:0]      bank_r  [NCH];
    logic [SEL_W-1:0]   ch_r;
    logic [VAL_W-1:0]   shift_r;
    logic [DW-1:0]      acc_r;
    logic [DW-1:0]      acc_adj_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_r;
    logic               busy_r;
    logic               frame_done_r;
    logic               wr_en_s;
    logic               take_frame_s;
    logic               rd_ok_s;
    logic               unused_s;

    // Saturating update of one stat register for a given opcode.
    function automatic logic [VAL_W-1:0] sat_op(input logic [VAL_W-1:0] cur,
                                                input logic [1:0]       op,
                                                input logic [VAL_W-1:0] opnd);
        logic [VAL_W:0] sum;
        logic [VAL_W-1:0] res;
        sum = {1'b0, cur} + {1'b0, opnd};
        case (op)
            2'b00:   res = opnd;
            2'b01:   res = sum[VAL_W] ? VAL_MAX : sum[VAL_W-1:0];
            2'b10:   res = (opnd > cur) ? {VAL_W{1'b0}} : (cur - opnd);
            2'b11:   res = {VAL_W{1'b0}};
            default: res = cur;
        endcase
        return res;
    endfunction

    // Double-dabble correction: add 3 to every nibble that is 5 or more.
    function automatic logic [DW-1:0] add3_all(input logic [DW-1:0] a);
        logic [DW-1:0] r;
        r = a;
        for (int i = 0; i < NDIG; i++) begin
            if (a[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = a[i*4 +: 4];
            end
        end
        return r;
    endfunction

    // Final word written into the bank: clamp to all nines, optionally blank leading zeros.
    function automatic logic [DW-1:0] store_word(input logic [DW-1:0] acc, input logic ovf);
        logic [DW-1:0] r;
        logic          lead;
        r = ovf ? {NDIG{4'h9}} : acc;
        lead = 1'b1;
`ifdef HUD_LEADING_ZERO_BLANK_EN
        for (int i = NDIG - 1; i >= 1; i--) begin
            if (lead && (r[i*4 +: 4] == 4'h0)) begin
                r[i*4 +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
`else
        lead = lead & 1'b0;
`endif
        return r;
    endfunction

    assign wr_en_s      = chipselect && write && (int'(address) < NCH);
    assign take_frame_s = frame_start && (state_r == ST_IDLE);
    assign acc_adj_s    = add3_all(acc_r);
    assign rd_ok_s      = (int'(rd_sel) < NCH);
    assign digit_bcd    = rd_ok_s ? bank_r[rd_sel] : {DW{1'b0}};
    assign busy         = busy_r;
    assign frame_done   = frame_done_r;
    assign unused_s     = ^writedata[29:VAL_W];

    // Stat registers take host writes; snapshot captures pre-write values at frame start.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (!reset) begin
                value_r[i] <= {VAL_W{1'b0}};
                snap_r[i]  <= {VAL_W{1'b0}};
            end else begin
                if (wr_en_s && (int'(address) == i)) begin
                    value_r[i] <= sat_op(value_r[i], writedata[31:30], writedata[VAL_W-1:0]);
                end
                if (take_frame_s) begin
                    snap_r[i] <= value_r[i];
                end
            end
        end
    end

    // Sweep state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic for the conversion sweep.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_start) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD:  state_s = ST_SHIFT;
            ST_SHIFT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = ST_STORE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_STORE: state_s = ST_NEXT;
            ST_NEXT: begin
                if (ch_r == LAST_CH) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Conversion datapath: channel index, shift register, BCD accumulator and bank.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ch_r    <= {SEL_W{1'b0}};
            shift_r <= {VAL_W{1'b0}};
            acc_r   <= {DW{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                bank_r[i] <= {DW{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: ch_r <= {SEL_W{1'b0}};
                ST_LOAD: begin
                    shift_r <= snap_r[ch_r];
                    acc_r   <= {DW{1'b0}};
                    cnt_r   <= CNT_W'(VAL_W - 1);
                    ovf_r   <= ({{(32-VAL_W){1'b0}}, snap_r[ch_r]} > MAX_DEC);
                end
                ST_SHIFT: begin
                    acc_r   <= {acc_adj_s[DW-2:0], shift_r[VAL_W-1]};
                    shift_r <= {shift_r[VAL_W-2:0], 1'b0};
                    cnt_r   <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
                ST_STORE: bank_r[ch_r] <= store_word(acc_r, ovf_r);
                ST_NEXT: begin
                    if (ch_r != LAST_CH) begin
                        ch_r <= ch_r + {{(SEL_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ch_r <= {SEL_W{1'b0}};
            endcase
        end
    end

    // Registered status outputs; reset aborts a sweep without a done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= (state_r == ST_NEXT) && (ch_r == LAST_CH);
        end
    end

endmodule

// File: tb/tb_hud_counter_bank.sv
// Scoreboard bench for hud_counter_bank: two instances (NDIG=3 and NDIG=2) share
// all inputs; stimulus pushes hand-computed channel values per sweep, a monitor
// pops on frame_done (or a probe request) and checks latency and every digit word.
module tb_hud_counter_bank;

    localparam int NCH = 4;
    localparam int LAT = 45;  // 1 + 4*(8+3)

    typedef struct {
        bit               probe;
        int               issue;
        logic [NCH*16-1:0] vals;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write;
    logic [3:0]  address;
    logic [31:0] writedata;
    logic        frame_start;
    logic [1:0]  rd_sel;
    logic [11:0] dig_a;
    logic [7:0]  dig_b;
    logic        busy_a, busy_b, fd_a, fd_b;
    logic        probe_req = 1'b0;
    bit          mon_active = 1'b0;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    exp_t        sb_q[$];

    hud_counter_bank #(.NCH(4), .VAL_W(8), .NDIG(3), .ADDR_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .frame_start(frame_start),
        .rd_sel(rd_sel), .digit_bcd(dig_a), .busy(busy_a), .frame_done(fd_a)
    );

    hud_counter_bank #(.NCH(4), .VAL_W(8), .NDIG(2), .ADDR_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .frame_start(frame_start),
        .rd_sel(rd_sel), .digit_bcd(dig_b), .busy(busy_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    // Count elapsed rising edges for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Display word for a value: clamp to all nines, optional blanking of leading zeros.
    function automatic logic [19:0] exp_digits(input int v, input int nd);
        int p = 1;
        int t = v;
        bit lead = 1'b1;
        logic [19:0] r = 20'd0;
        for (int i = 0; i < nd; i++) p = p * 10;
        if (v > p - 1) begin
            for (int i = 0; i < nd; i++) r[i*4 +: 4] = 4'h9;
        end else begin
            for (int i = 0; i < nd; i++) begin
                r[i*4 +: 4] = 4'(t % 10);
                t = t / 10;
            end
        end
`ifdef HUD_LEADING_ZERO_BLANK_EN
        for (int i = nd - 1; i >= 1; i--) begin
            if (lead && r[i*4 +: 4] == 4'h0) r[i*4 +: 4] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return r;
    endfunction

    function automatic logic [NCH*16-1:0] pk(input int v0, input int v1, input int v2, input int v3);
        return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
    endfunction

    // Monitor: pops the scoreboard whenever a sweep completes or a probe is requested.
    initial begin
        exp_t e;
        logic [19:0] ea, eb;
        int v;
        rd_sel = 2'd0;
        forever begin
            @(negedge clk);
            if (fd_a || fd_b || probe_req) begin
                mon_active = 1'b1;
                if (sb_q.size() == 0) begin
                    check("unexpected_output", {30'd0, fd_a, probe_req}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.probe) begin
                        check("probe_no_done", {31'd0, fd_a}, 32'd0);
                    end else begin
                        check("done_latency", cyc - e.issue, LAT);
                        check("done_b_aligned", {31'd0, fd_b}, 32'd1);
                        check("busy_low_at_done", {31'd0, busy_a}, 32'd0);
                    end
                    for (int ch = 0; ch < NCH; ch++) begin
                        rd_sel = 2'(ch);
                        #1;
                        v  = int'(e.vals[ch*16 +: 16]);
                        ea = exp_digits(v, 3);
                        eb = exp_digits(v, 2);
                        check($sformatf("digits3_ch%0d", ch), {20'd0, dig_a}, {20'd0, ea[11:0]});
                        check($sformatf("digits2_ch%0d", ch), {24'd0, dig_b}, {24'd0, eb[7:0]});
                    end
                end
                mon_active = 1'b0;
            end
        end
    end

    task automatic wr(input bit cs, input int addr, input logic [1:0] op, input int opnd);
        @(negedge clk);
        chipselect = cs;
        write      = 1'b1;
        address    = 4'(addr);
        writedata  = {op, 22'd0, 8'(opnd)};
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic start_sweep(input logic [NCH*16-1:0] vals);
        exp_t e;
        @(negedge clk);
        e.probe = 1'b0; e.issue = cyc; e.vals = vals;
        sb_q.push_back(e);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("busy_during_sweep", {31'd0, busy_a}, 32'd1);
    endtask

    task automatic probe(input logic [NCH*16-1:0] vals);
        exp_t e;
        @(posedge clk);
        e.probe = 1'b1; e.issue = cyc; e.vals = vals;
        sb_q.push_back(e);
        probe_req = 1'b1;
        @(posedge clk);
        probe_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !mon_active) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    // Directed stimulus.
    initial begin
        exp_t e;
        reset = 1'b0; chipselect = 1'b0; write = 1'b0; address = 4'd0;
        writedata = 32'd0; frame_start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy_a}, 32'd0);
        check("reset_done", {31'd0, fd_a}, 32'd0);
        reset = 1'b1;
        probe(pk(0, 0, 0, 0));
        wait_idle("reset_probe");

        // Sweep of all-zero channels.
        start_sweep(pk(0, 0, 0, 0));
        wait_idle("s1");

        // ADD saturates, SUB floors at zero.
        wr(1'b1, 2, 2'b00, 200);
        wr(1'b1, 2, 2'b01, 100);
        wr(1'b1, 1, 2'b00, 5);
        wr(1'b1, 1, 2'b10, 9);
        start_sweep(pk(0, 0, 255, 0));
        wait_idle("s2");

        // CLEAR, reload, clamp value, ignored writes.
        wr(1'b1, 1, 2'b00, 90);
        wr(1'b1, 1, 2'b11, 33);
        wr(1'b1, 1, 2'b00, 60);
        wr(1'b1, 0, 2'b00, 150);
        wr(1'b1, 4, 2'b00, 77);
        wr(1'b1, 15, 2'b00, 77);
        wr(1'b0, 3, 2'b00, 200);
        wr(1'b1, 3, 2'b00, 10);
        start_sweep(pk(150, 60, 255, 10));
        wait_idle("s3");

        // Same-cycle write lands after the snapshot; mid-sweep frame_start ignored.
        @(negedge clk);
        e.probe = 1'b0; e.issue = cyc; e.vals = pk(150, 60, 255, 10);
        sb_q.push_back(e);
        frame_start = 1'b1; chipselect = 1'b1; write = 1'b1;
        address = 4'd3; writedata = {2'b00, 22'd0, 8'd99};
        @(negedge clk);
        frame_start = 1'b0; chipselect = 1'b0; write = 1'b0;
        repeat (10) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_idle("s4");
        repeat (60) @(negedge clk);
        start_sweep(pk(150, 60, 255, 99));
        wait_idle("s5");

        // Operand upper bits ignored, exact-fit ADD, saturating ADD, plain SUB.
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 4'd0;
        writedata = {2'b00, 22'h3FFFFF, 8'd7};
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        wr(1'b1, 1, 2'b01, 195);
        wr(1'b1, 2, 2'b10, 55);
        wr(1'b1, 3, 2'b01, 200);
        start_sweep(pk(7, 255, 200, 255));
        wait_idle("s6");

        // Reset 20 cycles into a sweep aborts it and zeroes everything.
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        check("abort_done", {31'd0, fd_a}, 32'd0);
        repeat (60) @(negedge clk);
        probe(pk(0, 0, 0, 0));
        wait_idle("abort_probe");
        start_sweep(pk(0, 0, 0, 0));
        wait_idle("s7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hud_counter_bank.md
Name: hud_counter_bank

Overview:
Parametrised successor to the fixed per-stat number displays in the VGA HUD, which feed HP, ammo, clip and bag. Holds NCH game-stat registers written over the Avalon slave interface. Each register supports load, saturating add/subtract and clear. Once per frame, a sequential double-dabble engine converts a snapshot of every channel to NDIG BCD digits, and the sprite/glyph renderer reads those digits.

Parameters:
NCH, 4, number of stat channels (1..16)
VAL_W, 8, binary width of each stat value (4..16)
NDIG, 3, BCD digits produced per channel (1..5)
ADDR_W, 4, Avalon address width; must satisfy 2**ADDR_W >= NCH

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
address  in  ADDR_W  channel index
writedata  in  32  [31:30] opcode, [VAL_W-1:0] operand
frame_start  in  1  one-cycle pulse at start of vertical blank
rd_sel  in  $clog2(NCH) (min 1)  channel selected for digit readout
digit_bcd  out  NDIG*4  BCD digits of channel rd_sel; digit 0 (units) in [3:0]
busy  out  1  conversion sweep in progress
frame_done  out  1  one-cycle pulse when the sweep finishes

Behaviour:
- Reset (reset=0 at a clk edge) clears all value registers, snapshot registers and the BCD bank to 0. FSM goes to IDLE; busy=0 and frame_done=0.
- A reset asserted mid-sweep aborts the sweep. No partial results are retained.
- A write is accepted when chipselect=1 and write=1 and address<NCH; addresses >= NCH are ignored. The result is visible in the value register on the next cycle.
- Opcodes:
  - 00 LOAD: value = min(operand, 2**VAL_W-1).
  - 01 ADD: value = min(value+operand, 2**VAL_W-1), computed at VAL_W+1 bits.
  - 10 SUB: value = max(value-operand, 0).
  - 11 CLEAR: value = 0.
- frame_start with busy=0: all NCH values are copied to the snapshot in that cycle. Snapshot uses pre-write values; a same-cycle write lands in the value register only. busy rises the next cycle.
- frame_start with busy=1 is ignored. The sweep is not restarted and the pulse is not queued.
- FSM states:
  - IDLE: wait for frame_start.
  - LOAD: load snapshot[ch] into the shift register; clear the BCD accumulator.
  - SHIFT: VAL_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left one bit.
  - STORE: write the accumulator to bank[ch].
  - NEXT: if ch==NCH-1, go to IDLE and pulse frame_done; otherwise ch+1, go to LOAD.
- Sweep latency from frame_start to frame_done: 1 + NCH*(VAL_W+3) cycles. Default: 45.
- Overflow clamp: if a snapshot value > 10**NDIG-1, STORE writes all nines (every nibble 9).
- digit_bcd is a combinational read of bank[rd_sel]. It always shows the last completed conversion, so no tearing occurs during a sweep.
- rd_sel >= NCH returns all zeros.
- Each bank entry updates exactly at its STORE cycle.

Optional Feature:
Macro HUD_LEADING_ZERO_BLANK_EN.
- Defined: on STORE, leading zero nibbles above digit 0 are replaced with 4'hF (blank glyph code). Digit 0 is never blanked, so value 0 shows as F..F0. Default 7 shows FF7; 42 shows F42.
- Undefined: all digits are stored as plain BCD, including leading zeros. Default 7 shows 007.
- Latency, ports and clamp behaviour are identical in both builds.

Test Plan:
- Reset, then pulse frame_start. Expect busy=1 for the sweep, frame_done exactly 45 cycles after frame_start, and digit_bcd=12'h000 for all rd_sel.
- LOAD ch2=200, ADD ch2 100, then sweep. Expect ch2 value saturated at 255 and rd_sel=2 giving 12'h255.
- LOAD ch1=5, SUB ch1 9, then sweep. Expect 12'h000. Next: LOAD ch1=90, CLEAR ch1, LOAD ch1=60, sweep. Expect 12'h060.
- With NDIG=2, LOAD ch0=150 and sweep. Expect 8'h99 clamp. Also write address=NCH (4) with LOAD 77: expect no channel changed.
- Sweep of ch3=10: write LOAD ch3=99 in the same cycle as frame_start. Expect 12'h010 after this sweep, 12'h099 after the next. A second frame_start mid-sweep is ignored: a single frame_done.
- Drop reset mid-sweep (cycle 20), then release. Expect busy=0, bank zeroed, no frame_done. With HUD_LEADING_ZERO_BLANK_EN defined, ch0=7 reads 12'hFF7.
